// File: rtl/ddc_fs4_if.sv
// Sample-in / baseband-out bus of the fs/4 down-converter.
// The master drives the IF stream and controls; the slave returns I/Q results.
interface ddc_fs4_if #(
  parameter int DW = 16
);
  logic signed [DW-1:0] adc_data;
  logic                 adc_valid;
  logic                 sync;
  logic [2:0]           cut_ctl;
  logic signed [DW-1:0] ddc_out_i;
  logic signed [DW-1:0] ddc_out_q;
  logic                 ddc_out_valid;
  logic [15:0]          sat_cnt;

  modport master (
    output adc_data, adc_valid, sync, cut_ctl,
    input  ddc_out_i, ddc_out_q, ddc_out_valid, sat_cnt
  );

  modport slave (
    input  adc_data, adc_valid, sync, cut_ctl,
    output ddc_out_i, ddc_out_q, ddc_out_valid, sat_cnt
  );
endinterface

// File: rtl/ddc_fs4.sv
// fs/4 digital down-converter: multiplier-free NCO mix, integrate-and-dump
// decimation by 2^DEC_LOG2, then shift/saturate to DW-bit I/Q.
module ddc_fs4 #(
  parameter int DW       = 16,
  parameter int DEC_LOG2 = 2
) (
  input  logic      clk_ddc,
  input  logic      rst,
  ddc_fs4_if.slave  bus
);
  localparam int MW = DW + 1;
  localparam int AW = DW + 1 + DEC_LOG2;
  localparam logic signed [AW-1:0] MAX_V = AW'((2 ** (DW - 1)) - 1);
  localparam logic signed [AW-1:0] MIN_V = AW'(-(2 ** (DW - 1)));

  logic [1:0]           phase;
  logic [1:0]           sel;
  logic signed [MW-1:0] x_ext;
  logic signed [MW-1:0] x_neg;
  logic signed [MW-1:0] mix_i;
  logic signed [MW-1:0] mix_q;
  logic                 mix_valid;

  logic [DEC_LOG2-1:0]  cnt;
  logic signed [AW-1:0] acc_i;
  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] next_i;
  logic signed [AW-1:0] next_q;
  logic signed [AW-1:0] sum_i;
  logic signed [AW-1:0] sum_q;
  logic                 sum_valid;

  logic signed [AW-1:0] val_i;
  logic signed [AW-1:0] val_q;
  logic [DW-1:0]        cut_i;
  logic [DW-1:0]        cut_q;
  logic                 sat_i;
  logic                 sat_q;

  // A sync cycle forces the sample it accepts to phase 0.
  assign sel   = bus.sync ? 2'd0 : phase;
  assign x_ext = {bus.adc_data[DW-1], bus.adc_data};
  assign x_neg = -x_ext;

  always_ff @(posedge clk_ddc or posedge rst) begin
    if (rst) begin
      phase     <= '0;
      mix_i     <= '0;
      mix_q     <= '0;
      mix_valid <= 1'b0;
    end else begin
      mix_valid <= bus.adc_valid;
      if (bus.adc_valid) begin
        phase <= sel + 2'd1;
        case (sel)
          2'd0:    begin mix_i <= x_ext; mix_q <= '0;    end
          2'd1:    begin mix_i <= '0;    mix_q <= x_neg; end
          2'd2:    begin mix_i <= x_neg; mix_q <= '0;    end
          default: begin mix_i <= '0;    mix_q <= x_ext; end
        endcase
      end else if (bus.sync) begin
        phase <= 2'd0;
      end
    end
  end

  assign next_i = acc_i + {{DEC_LOG2{mix_i[MW-1]}}, mix_i};
  assign next_q = acc_q + {{DEC_LOG2{mix_q[MW-1]}}, mix_q};

  // Sync drops whatever mixed sample is waiting here; a dumped sum already
  // in sum_valid still reaches the output stage on this edge.
  always_ff @(posedge clk_ddc or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      sum_i     <= '0;
      sum_q     <= '0;
      sum_valid <= 1'b0;
    end else if (bus.sync) begin
      cnt       <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      sum_valid <= 1'b0;
    end else if (mix_valid) begin
      if (cnt == '1) begin
        sum_i     <= next_i;
        sum_q     <= next_q;
        sum_valid <= 1'b1;
        acc_i     <= '0;
        acc_q     <= '0;
        cnt       <= '0;
      end else begin
        acc_i     <= next_i;
        acc_q     <= next_q;
        cnt       <= cnt + DEC_LOG2'(1);
        sum_valid <= 1'b0;
      end
    end else begin
      sum_valid <= 1'b0;
    end
  end

  always_comb begin
    val_i = sum_i >>> bus.cut_ctl;
    val_q = sum_q >>> bus.cut_ctl;
    sat_i = (val_i > MAX_V) || (val_i < MIN_V);
    sat_q = (val_q > MAX_V) || (val_q < MIN_V);
    cut_i = val_i[DW-1:0];
    cut_q = val_q[DW-1:0];
    if (val_i > MAX_V)      cut_i = MAX_V[DW-1:0];
    else if (val_i < MIN_V) cut_i = MIN_V[DW-1:0];
    if (val_q > MAX_V)      cut_q = MAX_V[DW-1:0];
    else if (val_q < MIN_V) cut_q = MIN_V[DW-1:0];
  end

  always_ff @(posedge clk_ddc or posedge rst) begin
    if (rst) begin
      bus.ddc_out_i     <= '0;
      bus.ddc_out_q     <= '0;
      bus.ddc_out_valid <= 1'b0;
      bus.sat_cnt       <= '0;
    end else begin
      bus.ddc_out_valid <= sum_valid;
      if (sum_valid) begin
        bus.ddc_out_i <= cut_i;
        bus.ddc_out_q <= cut_q;
        if ((sat_i || sat_q) && (bus.sat_cnt != 16'hFFFF))
          bus.sat_cnt <= bus.sat_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_ddc_fs4.sv
// Bench for ddc_fs4: directed test-plan scenarios plus random streams checked
// against a sample-level cos/sin mix-and-sum model.
module tb_ddc_fs4;
  localparam int DW       = 16;
  localparam int DEC_LOG2 = 2;
  localparam int DEC      = 1 << DEC_LOG2;

  logic clk_ddc = 1'b0;
  logic rst     = 1'b0;

  ddc_fs4_if #(.DW(DW)) bus ();

  ddc_fs4 #(.DW(DW), .DEC_LOG2(DEC_LOG2)) dut (
    .clk_ddc (clk_ddc),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_ddc = ~clk_ddc;

  typedef struct {
    int i;
    int q;
    int sat;
    int edge_n;
  } strobe_t;

  strobe_t got[$];
  strobe_t exp_q[$];
  int edges    = 0;
  int checks   = 0;
  int failures = 0;

  always @(posedge clk_ddc) edges <= edges + 1;

  always @(negedge clk_ddc)
    if (bus.ddc_out_valid === 1'b1)
      got.push_back('{int'(bus.ddc_out_i), int'(bus.ddc_out_q), int'(bus.sat_cnt), edges});

  // Reference: an accepted sample is multiplied by cos/-sin of its phase and
  // joins the block sum one cycle later, unless a sync arrives first.
  int     cos_tab[4] = '{1, 0, -1, 0};
  int     sin_tab[4] = '{0, 1, 0, -1};
  int     mph, mcnt, msat, cut_now;
  bit     pend;
  int     pend_i, pend_q, pend_edge;
  longint macc_i, macc_q;

  function automatic int model_cut(input longint s, output bit sat);
    longint t;
    t   = s >>> cut_now;
    sat = 1'b0;
    if (t > 32767) begin
      sat = 1'b1;
      return 32767;
    end
    if (t < -32768) begin
      sat = 1'b1;
      return -32768;
    end
    return int'(t);
  endfunction

  task automatic model_reset();
    mph = 0; mcnt = 0; msat = 0; pend = 0;
    macc_i = 0; macc_q = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input int x, input bit v, input bit s);
    int ci, cq;
    bit si, sq;
    if (s) begin
      pend = 0; macc_i = 0; macc_q = 0; mcnt = 0; mph = 0;
    end
    if (pend) begin
      macc_i += pend_i;
      macc_q += pend_q;
      mcnt++;
      if (mcnt == DEC) begin
        ci = model_cut(macc_i, si);
        cq = model_cut(macc_q, sq);
        if ((si || sq) && msat < 65535) msat++;
        exp_q.push_back('{ci, cq, msat, pend_edge + 2});
        macc_i = 0; macc_q = 0; mcnt = 0;
      end
      pend = 0;
    end
    if (v) begin
      pend_i    = x * cos_tab[mph];
      pend_q    = -x * sin_tab[mph];
      pend      = 1;
      pend_edge = edges;
      mph       = (mph + 1) % 4;
    end
  endtask

  task automatic apply_sample(input int x, input bit v, input bit s);
    bus.adc_data  = 16'(x);
    bus.adc_valid = v;
    bus.sync      = s;
    @(posedge clk_ddc);
    #1;
    model_step(x, v, s);
    bus.adc_valid = 1'b0;
    bus.sync      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply_sample(0, 1'b0, 1'b0);
  endtask

  task automatic set_cut(input int c);
    bus.cut_ctl = 3'(c);
    cut_now     = c;
    got.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.ddc_out_i !== 16'sd0 || bus.ddc_out_q !== 16'sd0 ||
        bus.ddc_out_valid !== 1'b0 || bus.sat_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got i=%0d q=%0d v=%b sat=%0d, want all 0",
               bus.ddc_out_i, bus.ddc_out_q, bus.ddc_out_valid, bus.sat_cnt);
    end
    repeat (3) @(posedge clk_ddc);
    #1 rst = 1'b0;
    model_reset();
    idle(3);
    checks++;
    if (got.size() !== 0) begin
      failures++;
      $display("[TB] FAIL reset_no_strobe: got %0d strobes, want 0", got.size());
    end
  endtask

  task automatic test_dc();
    set_cut(0);
    for (int k = 0; k < 4 * DEC; k++) apply_sample(1000, 1'b1, k == 0);
    idle(4);
    checks++;
    if (got.size() !== 4) begin
      failures++;
      $display("[TB] FAIL dc_count: got %0d strobes, want 4", got.size());
    end
    foreach (got[k]) begin
      checks++;
      if (got[k].i !== 0 || got[k].q !== 0 || got[k].sat !== 0) begin
        failures++;
        $display("[TB] FAIL dc_strobe%0d: got i=%0d q=%0d sat=%0d, want 0 0 0",
                 k, got[k].i, got[k].q, got[k].sat);
      end
    end
  endtask

  task automatic test_cosine();
    int pat[4] = '{1000, 0, -1000, 0};
    int want[2] = '{2000, 1000};
    int last_cap;
    for (int c = 0; c < 2; c++) begin
      set_cut(c);
      last_cap = 0;
      for (int k = 0; k < 3 * DEC; k++) begin
        apply_sample(pat[k % 4], 1'b1, k == 0);
        if (k == 3) last_cap = edges;
      end
      idle(4);
      checks++;
      if (got.size() !== 3) begin
        failures++;
        $display("[TB] FAIL cos_count_cut%0d: got %0d strobes, want 3", c, got.size());
      end
      foreach (got[k]) begin
        checks++;
        if (got[k].i !== want[c] || got[k].q !== 0) begin
          failures++;
          $display("[TB] FAIL cos_cut%0d_strobe%0d: got i=%0d q=%0d, want i=%0d q=0",
                   c, k, got[k].i, got[k].q, want[c]);
        end
      end
      checks++;
      if (got.size() == 0 || got[0].edge_n !== last_cap + 2) begin
        failures++;
        $display("[TB] FAIL cos_latency_cut%0d: got edge %0d, want %0d", c,
                 (got.size() == 0) ? -1 : got[0].edge_n, last_cap + 2);
      end
    end
  endtask

  task automatic test_sine_gaps();
    int pat[4] = '{0, 1000, 0, -1000};
    for (int gap = 0; gap < 2; gap++) begin
      set_cut(0);
      for (int k = 0; k < 3 * DEC; k++) begin
        apply_sample(pat[k % 4], 1'b1, k == 0);
        if (gap == 1) idle(1);
      end
      idle(4);
      checks++;
      if (got.size() !== 3) begin
        failures++;
        $display("[TB] FAIL sin_count_gap%0d: got %0d strobes, want 3", gap, got.size());
      end
      foreach (got[k]) begin
        checks++;
        if (got[k].i !== 0 || got[k].q !== -2000) begin
          failures++;
          $display("[TB] FAIL sin_gap%0d_strobe%0d: got i=%0d q=%0d, want i=0 q=-2000",
                   gap, k, got[k].i, got[k].q);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int pat[4] = '{32767, 0, -32768, 0};
    int cuts[2] = '{0, 2};
    int want_i[2] = '{32767, 16383};
    for (int c = 0; c < 2; c++) begin
      set_cut(cuts[c]);
      for (int k = 0; k < 3 * DEC; k++) apply_sample(pat[k % 4], 1'b1, k == 0);
      idle(4);
      checks++;
      if (got.size() !== 3) begin
        failures++;
        $display("[TB] FAIL sat_count_cut%0d: got %0d strobes, want 3", cuts[c], got.size());
      end
      foreach (got[k]) begin
        checks++;
        if (got[k].i !== want_i[c] || got[k].q !== 0 ||
            got[k].sat !== ((c == 0) ? k + 1 : 3)) begin
          failures++;
          $display("[TB] FAIL sat_cut%0d_strobe%0d: got i=%0d q=%0d sat=%0d, want i=%0d q=0 sat=%0d",
                   cuts[c], k, got[k].i, got[k].q, got[k].sat, want_i[c],
                   (c == 0) ? k + 1 : 3);
        end
      end
    end
  endtask

  task automatic test_sync_mid();
    int pat[4] = '{1000, 0, -1000, 0};
    int last_cap;
    set_cut(0);
    apply_sample(1000, 1'b1, 1'b1);
    apply_sample(0, 1'b1, 1'b0);
    for (int k = 0; k < DEC; k++) apply_sample(pat[k], 1'b1, k == 0);
    last_cap = edges;
    idle(5);
    checks++;
    if (got.size() !== 1) begin
      failures++;
      $display("[TB] FAIL syncmid_count: got %0d strobes, want 1", got.size());
    end
    checks++;
    if (got.size() == 0 || got[0].i !== 2000 || got[0].q !== 0 ||
        got[0].edge_n !== last_cap + 2) begin
      failures++;
      $display("[TB] FAIL syncmid_strobe: got i=%0d q=%0d edge=%0d, want i=2000 q=0 edge=%0d",
               (got.size() == 0) ? 0 : got[0].i, (got.size() == 0) ? 0 : got[0].q,
               (got.size() == 0) ? -1 : got[0].edge_n, last_cap + 2);
    end
  endtask

  task automatic test_async_reset();
    int sat_pat[4] = '{32767, 0, -32768, 0};
    int cos_pat[4] = '{1000, 0, -1000, 0};
    int last_cap;
    set_cut(0);
    for (int k = 0; k < 2 * DEC + 1; k++) apply_sample(sat_pat[k % 4], 1'b1, k == 0);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.ddc_out_i !== 16'sd0 || bus.ddc_out_q !== 16'sd0 ||
        bus.ddc_out_valid !== 1'b0 || bus.sat_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL arst_outputs: got i=%0d q=%0d v=%b sat=%0d, want all 0",
               bus.ddc_out_i, bus.ddc_out_q, bus.ddc_out_valid, bus.sat_cnt);
    end
    model_reset();
    got.delete();
    idle(2);
    rst = 1'b0;
    idle(6);
    checks++;
    if (got.size() !== 0) begin
      failures++;
      $display("[TB] FAIL arst_no_strobe: got %0d strobes, want 0", got.size());
    end
    for (int k = 0; k < DEC; k++) apply_sample(cos_pat[k], 1'b1, 1'b0);
    last_cap = edges;
    idle(4);
    checks++;
    if (got.size() !== 1 || got[0].i !== 2000 || got[0].q !== 0 ||
        got[0].sat !== 0 || got[0].edge_n !== last_cap + 2) begin
      failures++;
      $display("[TB] FAIL arst_fresh_block: got n=%0d i=%0d sat=%0d edge=%0d, want n=1 i=2000 sat=0 edge=%0d",
               got.size(), (got.size() == 0) ? 0 : got[0].i,
               (got.size() == 0) ? 0 : got[0].sat,
               (got.size() == 0) ? -1 : got[0].edge_n, last_cap + 2);
    end
  endtask

  task automatic test_random();
    int x;
    bit v, s;
    for (int seg = 0; seg < 3; seg++) begin
      set_cut((seg == 0) ? 0 : int'($urandom_range(1, 7)));
      apply_sample(int'($urandom_range(0, 65535)) - 32768, 1'b1, 1'b1);
      for (int k = 0; k < 500; k++) begin
        x = int'($urandom_range(0, 65535)) - 32768;
        v = ($urandom_range(0, 3) != 0);
        s = ($urandom_range(0, (seg == 2) ? 7 : 23) == 0);
        apply_sample(x, v, s);
      end
      idle(4);
      checks++;
      if (got.size() !== exp_q.size()) begin
        failures++;
        $display("[TB] FAIL rand_count_seg%0d: got %0d strobes, want %0d",
                 seg, got.size(), exp_q.size());
      end
      for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
        checks++;
        if (got[k] !== exp_q[k]) begin
          failures++;
          $display("[TB] FAIL rand_seg%0d_strobe%0d: got i=%0d q=%0d sat=%0d edge=%0d, want i=%0d q=%0d sat=%0d edge=%0d",
                   seg, k, got[k].i, got[k].q, got[k].sat, got[k].edge_n,
                   exp_q[k].i, exp_q[k].q, exp_q[k].sat, exp_q[k].edge_n);
        end
      end
    end
  endtask

  initial begin
    bus.adc_data  = '0;
    bus.adc_valid = 1'b0;
    bus.sync      = 1'b0;
    bus.cut_ctl   = 3'd0;
    cut_now       = 0;
    model_reset();
    test_reset();
    test_dc();
    test_cosine();
    test_sine_gaps();
    test_saturation();
    test_sync_mid();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
